pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the unpipelined MIPS core.
- Sits directly downstream of the branch-offset shift_left_2 stage. It consumes the shifted, sign-extended immediate, forms branch and jump targets, and holds the PC.
- Fetches one instruction at a time over a valid/ready request and valid response interface, then presents each instruction to decode together with its PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branch_offset_sl2  in  32  sign-extended immediate already shifted left by 2.
- branch_taken  in  1  branch decision for the instruction currently presented.
- jump_en  in  1  J-type jump for the instruction currently presented.
- jump_index  in  26  instr[25:0] of the jump.
- stall  in  1  hold the current instruction and the PC.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  32  fetch address; equals the PC.
- imem_rsp_valid  in  1  fetched word valid.
- imem_rsp_data  in  32  fetched word.
- instr_valid  out  1  instr/instr_pc valid to decode.
- instr  out  32  captured instruction.
- instr_pc  out  32  PC of instr.
- pc_plus4  out  32  instr_pc + 4.
- retired_cnt  out  CNT_W  instructions retired; wraps.

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low.
- Reset values: PC=RESET_PC, state=FETCH, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=RESET_PC, retired_cnt=0.
- The first request is asserted on the first clock edge after rst_n is released.
- FSM states: FETCH, WAIT, DELIVER.
- FETCH:
  - imem_req_valid=1 and imem_addr=PC, both held stable until imem_req_ready=1.
  - On valid&ready the FSM moves to WAIT.
  - imem_rsp_valid is ignored in FETCH.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1: instr<=imem_rsp_data, instr_pc<=PC, state<=DELIVER.
  - There is no timeout; WAIT holds indefinitely.
- DELIVER:
  - instr_valid=1. branch_taken, jump_en and jump_index are sampled only in this state.
  - If stall=1, everything holds.
  - If stall=0, PC<=next_pc, retired_cnt increments, and the FSM moves to FETCH.
- Minimum throughput is one instruction per 3 cycles (ready=1, response one cycle after accept).
- next_pc priority is jump > branch > sequential:
  - jump: {pc_plus4[31:28], jump_index, 2'b00}
  - branch: pc_plus4 + branch_offset_sl2, modulo 2^32
  - else: pc_plus4
- pc_plus4 = instr_pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- Simultaneous jump_en and branch_taken: jump wins.
- stall outside DELIVER has no effect. An accepted request is never cancelled.
- retired_cnt wraps from all-ones to 0.
- Reset asserted mid-operation: immediate return to reset values. A stale response arriving after reset is dropped, because rsp_valid is ignored in FETCH.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_err (1 bit, resets to 0) and a HALT state.
  - If a selected next_pc has bits [1:0] != 0 when leaving DELIVER, PC is not updated, misalign_err<=1, and the FSM enters HALT.
  - In HALT: no requests, instr_valid=0, and only reset exits.
- Undefined:
  - next_pc[1:0] is forced to 2'b00. No extra port exists.

Decomposition:
- Package mips_pkg:
  - fetch_state_t enum {FETCH, WAIT, DELIVER, HALT}
  - constants INSTR_W=32, PC_INC=32'd4, JIDX_W=26
- Sub-module: pc_next_sel, combinational. Inputs instr_pc, branch_offset_sl2, branch_taken, jump_en, jump_index. Outputs next_pc and pc_plus4.
- The FSM and registers stay in the top module.

Test Plan:
- Reset release, ready=1, response 1 cycle after accept, data 32'h2008_0005 -> imem_addr=0, instr_valid in cycle 3 with instr=32'h2008_0005 and instr_pc=0; next request addr=4; retired_cnt=1.
- instr_pc=32'h0000_0010, branch_taken=1, branch_offset_sl2=32'hFFFF_FFF0 -> next imem_addr=32'h0000_0004. Then branch_offset_sl2=32'h0000_0100 -> next imem_addr=32'h0000_0114.
- instr_pc=32'h1000_0020, jump_en=1 and branch_taken=1, jump_index=26'h000_0040 -> next imem_addr=32'h1000_0100 (jump wins).
- stall=1 for 5 cycles in DELIVER plus ready held low for 3 cycles in FETCH -> instr, instr_pc and imem_addr stable; instr_valid held; no counter change.
- rst_n pulsed low while in WAIT, then a response arrives in FETCH -> outputs reset asynchronously, stale response ignored, fetch restarts at RESET_PC.
- PC_ALIGN_CHECK_EN defined, branch_offset_sl2=32'h0000_0002 -> misalign_err=1, no further requests. Undefined -> next address is pc_plus4+0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;
  localparam int          JIDX_W  = 26;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DELIVER,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential, branch or J-type jump target of the
// instruction currently held in decode.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr_pc,
  input  logic [INSTR_W-1:0] i_branch_offset_sl2,
  input  logic               i_branch_taken,
  input  logic               i_jump_en,
  input  logic [JIDX_W-1:0]  i_jump_index,
  output logic [INSTR_W-1:0] o_next_pc,
  output logic [INSTR_W-1:0] o_pc_plus4
);

  logic [INSTR_W-1:0] w_pc_plus4;

  assign w_pc_plus4 = i_instr_pc + PC_INC;
  assign o_pc_plus4 = w_pc_plus4;

  // Jump outranks branch, branch outranks fall-through; all sums wrap mod 2^32
  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jump_en) begin
      o_next_pc = {w_pc_plus4[31:28], i_jump_index, 2'b00};
    end else if (i_branch_taken) begin
      o_next_pc = w_pc_plus4 + i_branch_offset_sl2;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch sequencer.
// Optional build macro PC_ALIGN_CHECK_EN adds misalign_err and a HALT state;
// without it the low two bits of every new PC are cleared.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INSTR_W-1:0]  branch_offset_sl2,
  input  logic                branch_taken,
  input  logic                jump_en,
  input  logic [JIDX_W-1:0]   jump_index,
  input  logic                stall,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [INSTR_W-1:0]  imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INSTR_W-1:0]  imem_rsp_data,
  output logic                instr_valid,
  output logic [INSTR_W-1:0]  instr,
  output logic [INSTR_W-1:0]  instr_pc,
  output logic [INSTR_W-1:0]  pc_plus4,
`ifdef PC_ALIGN_CHECK_EN
  output logic                misalign_err,
`endif
  output logic [CNT_W-1:0]    retired_cnt
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic               r_armed;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_instr_pc;
  logic [CNT_W-1:0]   r_retired;
  logic [INSTR_W-1:0] w_next_pc;
  logic [INSTR_W-1:0] w_pc_plus4;
  logic [INSTR_W-1:0] w_pc_load;
  logic               w_req_valid;
  logic               w_instr_valid;
  logic               w_capture;
  logic               w_retire;
`ifdef PC_ALIGN_CHECK_EN
  logic               w_halt;
  logic               r_misalign;
`endif

  pc_next_sel u_pc_next_sel (
    .i_instr_pc          (r_instr_pc),
    .i_branch_offset_sl2 (branch_offset_sl2),
    .i_branch_taken      (branch_taken),
    .i_jump_en           (jump_en),
    .i_jump_index        (jump_index),
    .o_next_pc           (w_next_pc),
    .o_pc_plus4          (w_pc_plus4)
  );

`ifdef PC_ALIGN_CHECK_EN
  assign w_pc_load = w_next_pc;
`else
  assign w_pc_load = w_next_pc & ~32'h0000_0003;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_state_next;
  end

  // Keeps the first request off the bus until one edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_armed <= 1'b0;
    else        r_armed <= 1'b1;
  end

  // Next-state and handshake decode; rsp_valid only matters in WAIT
  always_comb begin
    w_state_next  = r_state;
    w_req_valid   = 1'b0;
    w_instr_valid = 1'b0;
    w_capture     = 1'b0;
    w_retire      = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    w_halt        = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        w_req_valid = r_armed;
        if (r_armed && imem_req_ready) w_state_next = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          w_capture    = 1'b1;
          w_state_next = DELIVER;
        end
      end
      DELIVER: begin
        w_instr_valid = 1'b1;
        if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
          if (w_next_pc[1:0] != 2'b00) begin
            w_halt       = 1'b1;
            w_state_next = HALT;
          end else begin
            w_retire     = 1'b1;
            w_state_next = FETCH;
          end
`else
          w_retire     = 1'b1;
          w_state_next = FETCH;
`endif
        end
      end
      HALT: begin
`ifdef PC_ALIGN_CHECK_EN
        w_state_next = HALT;
`else
        w_state_next = FETCH;
`endif
      end
      default: w_state_next = FETCH;
    endcase
  end

  // PC, captured instruction and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
      r_retired  <= '0;
    end else begin
      if (w_capture) begin
        r_instr    <= imem_rsp_data;
        r_instr_pc <= r_pc;
      end
      if (w_retire) begin
        r_pc      <= w_pc_load;
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_misalign <= 1'b0;
    else if (w_halt) r_misalign <= 1'b1;
  end

  assign misalign_err = r_misalign;
`endif

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_pc;
  assign instr_valid    = w_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign pc_plus4       = w_pc_plus4;
  assign retired_cnt    = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; adapts to PC_ALIGN_CHECK_EN.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] branch_offset_sl2;
  logic        branch_taken;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  pc_fetch_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .branch_offset_sl2 (branch_offset_sl2),
    .branch_taken      (branch_taken),
    .jump_en           (jump_en),
    .jump_index        (jump_index),
    .stall             (stall),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_addr         (imem_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_pc          (instr_pc),
    .pc_plus4          (pc_plus4),
`ifdef PC_ALIGN_CHECK_EN
    .misalign_err      (misalign_err),
`endif
    .retired_cnt       (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Wait for a request, check its address, optionally hold ready low, then accept
  task automatic request_phase(input logic [31:0] exp_addr, input int ready_delay, input string tag);
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_req_timeout got %b exp 1", tag, imem_req_valid);
    end
    checks++;
    if (imem_addr !== exp_addr) begin
      errors++;
      $display("[TB] FAIL %s_addr got %h exp %h", tag, imem_addr, exp_addr);
    end
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr) begin
        errors++;
        $display("[TB] FAIL %s_hold valid %b addr %h exp 1 %h", tag, imem_req_valid, imem_addr, exp_addr);
      end
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
  endtask

  // Return the word one cycle after accept and check what decode sees
  task automatic response_phase(input logic [31:0] data, input logic [31:0] exp_pc,
                                input logic [31:0] exp_p4, input string tag);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== data) begin
      errors++;
      $display("[TB] FAIL %s_instr valid %b instr %h exp 1 %h", tag, instr_valid, instr, data);
    end
    chk({tag, "_instr_pc"}, instr_pc, exp_pc);
    chk({tag, "_pc_plus4"}, pc_plus4, exp_p4);
  endtask

  // Release the current instruction with the given control flow decision
  task automatic deliver(input logic bt, input logic [31:0] off, input logic je,
                         input logic [25:0] ji, input string tag);
    branch_taken      = bt;
    branch_offset_sl2 = off;
    jump_en           = je;
    jump_index        = ji;
    stall             = 1'b0;
    @(negedge clk);
    branch_taken      = 1'b0;
    branch_offset_sl2 = 32'h0;
    jump_en           = 1'b0;
    jump_index        = 26'h0;
    exp_cnt           = exp_cnt + 32'd1;
    chk({tag, "_retired"}, retired_cnt, exp_cnt);
    chk({tag, "_valid_drop"}, {31'b0, instr_valid}, 32'h0);
  endtask

  task automatic applyStimulus_seq(input logic [31:0] addr, input logic [31:0] data,
                                   input logic [31:0] p4, input string tag);
    request_phase(addr, 0, tag);
    response_phase(data, addr, p4, tag);
    deliver(1'b0, 32'h0, 1'b0, 26'h0, tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    branch_offset_sl2 = 32'h0;
    branch_taken = 1'b0;
    jump_en = 1'b0;
    jump_index = 26'h0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_retired", retired_cnt, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_req_before_edge", {31'b0, imem_req_valid}, 32'h0);
    @(negedge clk);
    chk("rel_req_after_edge", {31'b0, imem_req_valid}, 32'h1);
  endtask

  task automatic test_sequential();
    request_phase(32'h0, 0, "seq0");
    response_phase(32'h2008_0005, 32'h0, 32'h4, "seq0");
    deliver(1'b0, 32'h0, 1'b0, 26'h0, "seq0");
    applyStimulus_seq(32'h4, 32'h1111_0004, 32'h8, "seq4");
    applyStimulus_seq(32'h8, 32'h1111_0008, 32'hC, "seq8");
    applyStimulus_seq(32'hC, 32'h1111_000C, 32'h10, "seqC");
  endtask

  task automatic test_branch();
    request_phase(32'h10, 0, "br_back");
    response_phase(32'h1000_FFFC, 32'h10, 32'h14, "br_back");
    deliver(1'b1, 32'hFFFF_FFF0, 1'b0, 26'h0, "br_back");
    applyStimulus_seq(32'h4, 32'h2222_0004, 32'h8, "br_s4");
    applyStimulus_seq(32'h8, 32'h2222_0008, 32'hC, "br_s8");
    applyStimulus_seq(32'hC, 32'h2222_000C, 32'h10, "br_sC");
    request_phase(32'h10, 0, "br_fwd");
    response_phase(32'h1000_0040, 32'h10, 32'h14, "br_fwd");
    deliver(1'b1, 32'h0000_0100, 1'b0, 26'h0, "br_fwd");
    request_phase(32'h114, 0, "br_far");
    response_phase(32'h1000_3FFF, 32'h114, 32'h118, "br_far");
    deliver(1'b1, 32'h0FFF_FF08, 1'b0, 26'h0, "br_far");
  endtask

  task automatic test_jump();
    request_phase(32'h1000_0020, 0, "jmp");
    response_phase(32'h0800_0040, 32'h1000_0020, 32'h1000_0024, "jmp");
    deliver(1'b1, 32'h0000_0010, 1'b1, 26'h000_0040, "jmp");
  endtask

  task automatic test_stall();
    request_phase(32'h1000_0100, 3, "stall");
    response_phase(32'hABCD_1234, 32'h1000_0100, 32'h1000_0104, "stall");
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'hABCD_1234 || instr_pc !== 32'h1000_0100 ||
          imem_addr !== 32'h1000_0100 || imem_req_valid !== 1'b0 || retired_cnt !== exp_cnt) begin
        errors++;
        $display("[TB] FAIL stall_hold v %b i %h pc %h a %h rq %b cnt %h exp 1 abcd1234 10000100 10000100 0 %h",
                 instr_valid, instr, instr_pc, imem_addr, imem_req_valid, retired_cnt, exp_cnt);
      end
    end
    deliver(1'b0, 32'h0, 1'b0, 26'h0, "stall_rel");
  endtask

  task automatic test_wrap();
    request_phase(32'h1000_0104, 0, "wrap_pre");
    response_phase(32'h0000_0000, 32'h1000_0104, 32'h1000_0108, "wrap_pre");
    deliver(1'b1, 32'hEFFF_FEF4, 1'b0, 26'h0, "wrap_pre");
    request_phase(32'hFFFF_FFFC, 0, "wrap");
    response_phase(32'h2400_0001, 32'hFFFF_FFFC, 32'h0000_0000, "wrap");
    deliver(1'b0, 32'h0, 1'b0, 26'h0, "wrap");
  endtask

  task automatic test_misalign();
    request_phase(32'h0, 0, "mis");
    response_phase(32'h1000_0000, 32'h0, 32'h4, "mis");
`ifdef PC_ALIGN_CHECK_EN
    branch_taken      = 1'b1;
    branch_offset_sl2 = 32'h0000_0002;
    stall             = 1'b0;
    @(negedge clk);
    branch_taken      = 1'b0;
    branch_offset_sl2 = 32'h0;
    chk("mis_err", {31'b0, misalign_err}, 32'h1);
    chk("mis_retired", retired_cnt, exp_cnt);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mis_halt req %b iv %b exp 0 0", imem_req_valid, instr_valid);
      end
    end
`else
    deliver(1'b1, 32'h0000_0002, 1'b0, 26'h0, "mis");
`endif
  endtask

  task automatic test_reset_mid();
    if (imem_req_valid === 1'b1) request_phase(32'h4, 0, "rmid_pre");
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rmid_instr_valid", {31'b0, instr_valid}, 32'h0);
    chk("rmid_instr", instr, 32'h0);
    chk("rmid_instr_pc", instr_pc, 32'h0);
    chk("rmid_addr", imem_addr, 32'h0);
    chk("rmid_retired", retired_cnt, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    chk("rmid_mis_err", {31'b0, misalign_err}, 32'h0);
`endif
    exp_cnt = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== 32'h0) begin
        errors++;
        $display("[TB] FAIL rmid_stale rq %b iv %b i %h a %h exp 1 0 0 0",
                 imem_req_valid, instr_valid, instr, imem_addr);
      end
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    request_phase(32'h0, 0, "rmid_post");
    response_phase(32'h3C01_0001, 32'h0, 32'h4, "rmid_post");
    deliver(1'b0, 32'h0, 1'b0, 26'h0, "rmid_post");
    request_phase(32'h4, 0, "rmid_next");
  endtask

  task automatic checkOutput();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_misalign();
    test_reset_mid();
    checkOutput();
    $finish;
  end

endmodule
